// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin lock arbiter sharing one I2C wishbone controller between requesters.
// The grant is held across a whole I2C sequence; a watchdog reclaims an idle grant.
module i2c_bus_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 160000
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NUM_REQ-1:0]     i_req,
    output logic [NUM_REQ-1:0]     o_gnt,
    input  logic [NUM_REQ-1:0]     i_wren,
    input  logic [NUM_REQ-1:0]     i_ren,
    input  logic [3*NUM_REQ-1:0]   i_addr,
    input  logic [8*NUM_REQ-1:0]   i_data,
    output logic [7:0]             o_rdata,
    output logic [NUM_REQ-1:0]     o_done,
    output logic [NUM_REQ-1:0]     o_data_val,
    output logic [NUM_REQ-1:0]     o_timeout,
    output logic                   o_busy,
    output logic                   o_wb_wren,
    output logic                   o_wb_ren,
    output logic [2:0]             o_wb_addr,
    output logic [7:0]             o_wb_data,
    input  logic [7:0]             i_wb_data,
    input  logic                   i_wb_data_val,
    input  logic                   i_wb_done
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, XFER, RELEASE} state_t;

    state_t          state, state_d;
    logic [IW-1:0]   owner, last_winner, pick;
    logic            pick_valid, is_write, owner_req, owner_wr, owner_rd;
    logic            cmp_ok, expire, wd_clear, wd_active;
    logic [31:0]     count;
    int              s;

    // Scan downward so the closest set bit after last_winner is the one kept.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        s          = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            s = int'(last_winner) + i;
            if (s >= NUM_REQ) s = s - NUM_REQ;
            if (i_req[IW'(s)]) begin
                pick       = IW'(s);
                pick_valid = 1'b1;
            end
        end
    end

    assign owner_req = i_req[owner];
    assign owner_wr  = i_wren[owner];
    assign owner_rd  = i_ren[owner];
    assign cmp_ok    = is_write ? i_wb_done : i_wb_data_val;
    assign expire    = count == 32'(TIMEOUT_CYCLES - 1);
    assign wd_active = (state == GRANT) || (state == XFER);
    assign wd_clear  = owner_wr || owner_rd || i_wb_done || i_wb_data_val;
    assign o_busy    = state != IDLE;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = pick_valid ? GRANT : IDLE;
            GRANT:   state_d = expire ? IDLE : !owner_req ? RELEASE : (owner_wr || owner_rd) ? XFER : GRANT;
            XFER:    state_d = cmp_ok ? (owner_req ? GRANT : RELEASE) : expire ? IDLE : XFER;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            owner       <= '0;
            last_winner <= IW'(NUM_REQ - 1);
            is_write    <= 1'b0;
            count       <= '0;
            o_gnt       <= '0;
            o_done      <= '0;
            o_data_val  <= '0;
            o_timeout   <= '0;
            o_rdata     <= '0;
            o_wb_wren   <= 1'b0;
            o_wb_ren    <= 1'b0;
            o_wb_addr   <= '0;
            o_wb_data   <= '0;
        end else begin
            state      <= state_d;
            o_wb_wren  <= 1'b0;
            o_wb_ren   <= 1'b0;
            o_done     <= '0;
            o_data_val <= '0;
            o_timeout  <= '0;
            count      <= (wd_active && !wd_clear) ? count + 32'd1 : '0;
            case (state)
                IDLE: if (pick_valid) begin
                    owner       <= pick;
                    last_winner <= pick;
                    o_gnt       <= NUM_REQ'(1) << pick;
                end
                GRANT: if (expire) begin
                    o_timeout[owner] <= 1'b1;
                    o_gnt            <= '0;
                end else if (!owner_req) begin
                    o_gnt <= '0;
                end else if (owner_wr || owner_rd) begin
                    o_wb_wren <= owner_wr;
                    o_wb_ren  <= !owner_wr;
                    is_write  <= owner_wr;
                    o_wb_addr <= i_addr[3*int'(owner) +: 3];
                    o_wb_data <= i_data[8*int'(owner) +: 8];
                end
                XFER: if (cmp_ok) begin
                    if (is_write) o_done[owner] <= 1'b1;
                    else begin
                        o_data_val[owner] <= 1'b1;
                        o_rdata           <= i_wb_data;
                    end
                    if (!owner_req) o_gnt <= '0;
                end else if (expire) begin
                    o_timeout[owner] <= 1'b1;
                    o_gnt            <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter: cycle-exact vector table with a scoreboard queue, plus timeout and async-reset sequences.
module tb_i2c_bus_arbiter;
    logic        i_clk, i_reset;
    logic [1:0]  i_req, i_wren, i_ren;
    logic [5:0]  i_addr;
    logic [15:0] i_data;
    logic [7:0]  i_wb_data;
    logic        i_wb_data_val, i_wb_done;
    logic [1:0]  o_gnt, o_done, o_data_val, o_timeout;
    logic [7:0]  o_rdata, o_wb_data;
    logic        o_busy, o_wb_wren, o_wb_ren;
    logic [2:0]  o_wb_addr;

    int n_cmp = 0;
    int n_bad = 0;

    i2c_bus_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(8)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .o_gnt(o_gnt),
        .i_wren(i_wren), .i_ren(i_ren), .i_addr(i_addr), .i_data(i_data),
        .o_rdata(o_rdata), .o_done(o_done), .o_data_val(o_data_val),
        .o_timeout(o_timeout), .o_busy(o_busy), .o_wb_wren(o_wb_wren),
        .o_wb_ren(o_wb_ren), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
        .i_wb_data(i_wb_data), .i_wb_data_val(i_wb_data_val), .i_wb_done(i_wb_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0]  req, wr, rd;
        logic [5:0]  addr;
        logic [15:0] data;
        logic [7:0]  wbd;
        logic        dv, dn;
        logic [1:0]  gnt;
        logic        wbw, wbr;
        logic [2:0]  wba;
        logic [7:0]  wbdat;
        logic [1:0]  done, dval;
        logic [7:0]  rdata;
        logic        busy;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic vec_t mk(logic [1:0] req, logic [1:0] wr, logic [1:0] rd, logic [5:0] addr,
                                logic [15:0] data, logic [7:0] wbd, logic dv, logic dn,
                                logic [1:0] gnt, logic wbw, logic wbr, logic [2:0] wba,
                                logic [7:0] wbdat, logic [1:0] done, logic [1:0] dval,
                                logic [7:0] rdata, logic busy);
        vec_t v;
        v.req = req; v.wr = wr; v.rd = rd; v.addr = addr; v.data = data; v.wbd = wbd;
        v.dv = dv; v.dn = dn; v.gnt = gnt; v.wbw = wbw; v.wbr = wbr; v.wba = wba;
        v.wbdat = wbdat; v.done = done; v.dval = dval; v.rdata = rdata; v.busy = busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        i_req = v.req; i_wren = v.wr; i_ren = v.rd; i_addr = v.addr; i_data = v.data;
        i_wb_data = v.wbd; i_wb_data_val = v.dv; i_wb_done = v.dn;
    endtask

    initial begin
        vec_t e;
        int cycles;
        i_reset = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_gnt", o_gnt, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_wb", {o_wb_wren, o_wb_ren, o_wb_addr, o_wb_data}, 0);
        chk("rst_pulses", {o_done, o_data_val, o_timeout, o_rdata}, 0);
        i_reset = 1'b0;

        //            req wr rd addr   data      wbd    dv dn  gnt wbw wbr wba wbdat  done dval rdata  busy
        vecs.push_back(mk(3, 0, 0, 6'o00, 16'h0000, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1));
        vecs.push_back(mk(3, 0, 0, 6'o00, 16'h0000, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1));
        vecs.push_back(mk(2, 0, 0, 6'o00, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1));
        vecs.push_back(mk(2, 0, 0, 6'o00, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk(2, 0, 0, 6'o00, 16'h0000, 8'h00, 0, 0, 2, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1));
        vecs.push_back(mk(3, 1, 0, 6'o05, 16'h0077, 8'h00, 0, 0, 2, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1));
        vecs.push_back(mk(3, 0, 2, 6'o30, 16'h0000, 8'h00, 0, 0, 2, 0, 1, 3, 8'h00, 0, 0, 8'h00, 1));
        vecs.push_back(mk(3, 0, 0, 6'o00, 16'h0000, 8'h00, 0, 1, 2, 0, 0, 3, 8'h00, 0, 0, 8'h00, 1));
        vecs.push_back(mk(3, 0, 0, 6'o00, 16'h0000, 8'hA5, 1, 0, 2, 0, 0, 3, 8'h00, 0, 2, 8'hA5, 1));
        vecs.push_back(mk(3, 0, 0, 6'o00, 16'h0000, 8'h00, 0, 0, 2, 0, 0, 3, 8'h00, 0, 0, 8'hA5, 1));
        vecs.push_back(mk(3, 2, 2, 6'o20, 16'h3C00, 8'h00, 0, 0, 2, 1, 0, 2, 8'h3C, 0, 0, 8'hA5, 1));
        vecs.push_back(mk(3, 0, 0, 6'o00, 16'h0000, 8'h00, 0, 1, 2, 0, 0, 2, 8'h3C, 2, 0, 8'hA5, 1));
        vecs.push_back(mk(1, 0, 0, 6'o00, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 2, 8'h3C, 0, 0, 8'hA5, 1));
        vecs.push_back(mk(1, 0, 0, 6'o00, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 2, 8'h3C, 0, 0, 8'hA5, 0));
        vecs.push_back(mk(1, 0, 0, 6'o00, 16'h0000, 8'h00, 0, 0, 1, 0, 0, 2, 8'h3C, 0, 0, 8'hA5, 1));
        vecs.push_back(mk(1, 1, 0, 6'o03, 16'h0040, 8'h00, 0, 0, 1, 1, 0, 3, 8'h40, 0, 0, 8'hA5, 1));
        vecs.push_back(mk(1, 0, 0, 6'o00, 16'h0000, 8'h00, 0, 0, 1, 0, 0, 3, 8'h40, 0, 0, 8'hA5, 1));
        vecs.push_back(mk(1, 0, 0, 6'o00, 16'h0000, 8'h00, 0, 1, 1, 0, 0, 3, 8'h40, 1, 0, 8'hA5, 1));
        vecs.push_back(mk(1, 0, 1, 6'o01, 16'h0000, 8'h00, 0, 0, 1, 0, 1, 1, 8'h00, 0, 0, 8'hA5, 1));
        vecs.push_back(mk(0, 0, 0, 6'o00, 16'h0000, 8'h00, 0, 0, 1, 0, 0, 1, 8'h00, 0, 0, 8'hA5, 1));
        vecs.push_back(mk(0, 0, 0, 6'o00, 16'h0000, 8'h5A, 1, 0, 0, 0, 0, 1, 8'h00, 0, 1, 8'h5A, 1));
        vecs.push_back(mk(0, 0, 0, 6'o00, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 1, 8'h00, 0, 0, 8'h5A, 0));

        foreach (vecs[i]) begin
            drive(vecs[i]);
            exp_q.push_back(vecs[i]);
            @(negedge i_clk);
            e = exp_q.pop_front();
            chk($sformatf("v%0d_gnt", i), o_gnt, e.gnt);
            chk($sformatf("v%0d_wb_strobes", i), {o_wb_wren, o_wb_ren}, {e.wbw, e.wbr});
            chk($sformatf("v%0d_wb_addr", i), o_wb_addr, e.wba);
            chk($sformatf("v%0d_wb_data", i), o_wb_data, e.wbdat);
            chk($sformatf("v%0d_done", i), o_done, e.done);
            chk($sformatf("v%0d_data_val", i), o_data_val, e.dval);
            chk($sformatf("v%0d_rdata", i), o_rdata, e.rdata);
            chk($sformatf("v%0d_busy", i), o_busy, e.busy);
            chk($sformatf("v%0d_timeout", i), o_timeout, 0);
        end
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Watchdog: owner 1 reads and the controller never answers.
        i_req = 2'b10;
        @(negedge i_clk);
        chk("to_gnt", o_gnt, 2'b10);
        i_ren = 2'b10;
        @(negedge i_clk);
        chk("to_wb_ren", o_wb_ren, 1);
        i_ren = 2'b00;
        cycles = 0;
        while (cycles < 30 && o_timeout == 2'b00) begin
            @(negedge i_clk);
            cycles++;
        end
        chk("to_cycle", cycles, 8);
        chk("to_pulse", o_timeout, 2'b10);
        chk("to_gnt_clr", o_gnt, 0);
        i_req = 2'b00;
        @(negedge i_clk);
        chk("to_pulse_end", o_timeout, 0);
        i_wb_data = 8'hEE;
        i_wb_data_val = 1'b1;
        @(negedge i_clk);
        i_wb_data_val = 1'b0;
        chk("to_late_dval", o_data_val, 0);
        chk("to_late_rdata", o_rdata, 8'h5A);
        i_req = 2'b11;
        @(negedge i_clk);
        chk("to_rr_next", o_gnt, 2'b01);

        // Async reset while owner 0 has a read in flight.
        i_ren = 2'b01;
        @(negedge i_clk);
        i_ren = 2'b00;
        chk("ar_wb_ren", o_wb_ren, 1);
        @(posedge i_clk);
        #2 i_reset = 1'b1;
        #1;
        chk("ar_gnt", o_gnt, 0);
        chk("ar_busy", o_busy, 0);
        chk("ar_outs", {o_done, o_data_val, o_timeout, o_wb_wren, o_wb_ren}, 0);
        @(negedge i_clk);
        i_reset = 1'b0;
        i_req = 2'b10;
        i_wb_data = 8'h11;
        i_wb_data_val = 1'b1;
        @(negedge i_clk);
        i_wb_data_val = 1'b0;
        chk("ar_regrant", o_gnt, 2'b10);
        chk("ar_stale_dval", o_data_val, 0);
        i_req = 2'b00;
        @(negedge i_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
